// File: rtl/pueo_clk_phase_track.sv
// ---------------------------------------------------------------------------
// pueo_clk_phase_track
//
// Tracks the phase of a slow sync toggle coming from the syncclk domain and
// turns it into a one-hot phase and a once-per-period sync pulse in the local
// fabric clock domain.
//
// The first toggle edge aligns the phase. Every later edge is checked against
// the running phase:
//   - a lock state machine acquires and holds lock,
//   - isolated misaligned edges are tolerated and only counted,
//   - a watchdog drops lock when the toggle stops.
//
// Ports:
//   aclk           fabric clock
//   aresetn        synchronous active-low reset
//   sync_toggle_i  asynchronous toggle from the syncclk domain
//   err_clr_i      clears err_cnt_o (wins over a simultaneous increment)
//   phase_o        registered one-hot phase, bit i high while phase is i
//   sync_o         one-cycle pulse per period at phase OFFSET
//   locked_o       high while the state machine is LOCKED
//   state_o        0 = UNLOCKED, 1 = ACQUIRE, 2 = LOCKED
//   err_cnt_o      saturating count of misaligned edges seen while LOCKED
// ---------------------------------------------------------------------------
module pueo_clk_phase_track #(
  parameter int PERIOD       = 4,
  parameter int SYNC_STAGES  = 3,
  parameter     EDGE_MODE    = "RISE",
  parameter int OFFSET       = 0,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int TIMEOUT      = 64,
  parameter int ERR_W        = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              sync_toggle_i,
  input  logic              err_clr_i,
  output logic [PERIOD-1:0] phase_o,
  output logic              sync_o,
  output logic              locked_o,
  output logic [1:0]        state_o,
  output logic [ERR_W-1:0]  err_cnt_o
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN  = (TIMEOUT != 0);

  localparam logic [CNT_W-1:0]  PHASE_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  PHASE_OFS  = CNT_W'(OFFSET);
  localparam logic [GOOD_W-1:0] LOCK_MAX   = GOOD_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(UNLOCK_COUNT);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] syncChain_q;
  logic syncDly_q;
  logic edgeDet;

  logic [CNT_W-1:0]  phaseCnt_q, phaseCnt_d;
  logic [PERIOD-1:0] phaseOh;
  logic [PERIOD-1:0] phaseOut_q;
  logic              syncOut_q;
  logic              aligned;
  logic              realign;

  state_e            state_q, state_d;
  logic              locked_q;
  logic [GOOD_W-1:0] goodCnt_q, goodCnt_d, goodInc;
  logic [MISS_W-1:0] missCnt_q, missCnt_d, missInc;
  logic [IDLE_W-1:0] idleCnt_q, idleCnt_d, idleInc;
  logic              idleSat;
  logic              timeoutHit;
  logic [ERR_W-1:0]  errCnt_q, errCnt_d;
  logic              errInc;

  // The toggle crosses into aclk through a plain flop chain; syncDly_q holds
  // the previous settled level so an edge can be detected one flop later.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      syncChain_q <= '0;
      syncDly_q   <= 1'b0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], sync_toggle_i};
      syncDly_q   <= syncChain_q[SYNC_STAGES-1];
    end
  end

  // Edge flavour is fixed at elaboration: rising edges only, or any change.
  generate
    if (EDGE_MODE == "BOTH") begin : gEdgeBoth
      assign edgeDet = syncChain_q[SYNC_STAGES-1] ^ syncDly_q;
    end else begin : gEdgeRise
      assign edgeDet = syncChain_q[SYNC_STAGES-1] & ~syncDly_q;
    end
  endgenerate

  // A sync edge is on-grid when it lands in the cycle where the counter is
  // about to wrap by itself; a realign forces that wrap instead.
  assign aligned = (phaseCnt_q == PHASE_LAST);

  always_comb begin
    phaseCnt_d = phaseCnt_q + CNT_W'(1);
    if (realign || aligned) begin
      phaseCnt_d = '0;
    end
  end

  always_comb begin
    phaseOh = '0;
    for (int i = 0; i < PERIOD; i++) begin
      phaseOh[i] = (phaseCnt_q == CNT_W'(i));
    end
  end

  // Phase counter and its registered decodes; never gated by lock state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phaseCnt_q <= '0;
      phaseOut_q <= '0;
      syncOut_q  <= 1'b0;
    end else begin
      phaseCnt_q <= phaseCnt_d;
      phaseOut_q <= phaseOh;
      syncOut_q  <= (phaseCnt_q == PHASE_OFS);
    end
  end

  // Watchdog: cycles since the last detected edge, saturating at TIMEOUT.
  // The timeout fires only on the cycle the count first reaches TIMEOUT, and
  // an edge in that same cycle resets the count and takes priority.
  assign idleSat    = (idleCnt_q == IDLE_MAX);
  assign idleInc    = idleCnt_q + IDLE_W'(1);
  assign timeoutHit = WD_EN && !edgeDet && !idleSat && (idleInc == IDLE_MAX);

  always_comb begin
    idleCnt_d = idleCnt_q;
    if (edgeDet) begin
      idleCnt_d = '0;
    end else if (!idleSat) begin
      idleCnt_d = idleInc;
    end
  end

  assign goodInc = goodCnt_q + GOOD_W'(1);
  assign missInc = missCnt_q + MISS_W'(1);

  // Lock state machine, next-state half. Only edge-detect cycles and the
  // watchdog move it. In LOCKED a misaligned edge leaves the phase alone
  // until UNLOCK_COUNT of them arrive back to back.
  always_comb begin
    state_d   = state_q;
    goodCnt_d = goodCnt_q;
    missCnt_d = missCnt_q;
    realign   = 1'b0;
    errInc    = 1'b0;
    if (edgeDet) begin
      case (state_q)
        ST_UNLOCKED: begin
          realign   = 1'b1;
          goodCnt_d = '0;
          missCnt_d = '0;
          state_d   = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (aligned) begin
            goodCnt_d = goodInc;
            if (goodInc == LOCK_MAX) begin
              missCnt_d = '0;
              state_d   = ST_LOCKED;
            end
          end else begin
            realign   = 1'b1;
            goodCnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (aligned) begin
            missCnt_d = '0;
          end else begin
            errInc = 1'b1;
            if (missInc == MISS_MAX) begin
              realign   = 1'b1;
              goodCnt_d = '0;
              missCnt_d = '0;
              state_d   = ST_ACQUIRE;
            end else begin
              missCnt_d = missInc;
            end
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
        end
      endcase
    end else if (timeoutHit && (state_q != ST_UNLOCKED)) begin
      state_d   = ST_UNLOCKED;
      goodCnt_d = '0;
      missCnt_d = '0;
    end
  end

  // Error counter saturates; a clear request overrides a same-cycle increment.
  always_comb begin
    errCnt_d = errCnt_q;
    if (err_clr_i) begin
      errCnt_d = '0;
    end else if (errInc && !(&errCnt_q)) begin
      errCnt_d = errCnt_q + ERR_W'(1);
    end
  end

  // Lock state machine register half plus its counters and status outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_UNLOCKED;
      locked_q  <= 1'b0;
      goodCnt_q <= '0;
      missCnt_q <= '0;
      idleCnt_q <= '0;
      errCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      locked_q  <= (state_d == ST_LOCKED);
      goodCnt_q <= goodCnt_d;
      missCnt_q <= missCnt_d;
      idleCnt_q <= idleCnt_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign phase_o   = phaseOut_q;
  assign sync_o    = syncOut_q;
  assign locked_o  = locked_q;
  assign state_o   = state_q;
  assign err_cnt_o = errCnt_q;

endmodule

// File: tb/tb_pueo_clk_phase_track.sv
// ---------------------------------------------------------------------------
// tb_pueo_clk_phase_track
//
// Directed bench for pueo_clk_phase_track. Instance A uses the defaults
// (PERIOD=4, RISE edges, LOCK_COUNT=4, UNLOCK_COUNT=2, TIMEOUT=64) and is
// driven from a table of toggle rises; instance B uses EDGE_MODE="BOTH" and
// covers lock-up on both edges plus a mid-lock reset.
// ---------------------------------------------------------------------------
module tb_pueo_clk_phase_track;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       aresetnA, toggleA, errClrA;
  logic [3:0] phaseA;
  logic       syncA, lockedA;
  logic [1:0] stateA;
  logic [15:0] errA;

  logic       aresetnB, toggleB, errClrB;
  logic [3:0] phaseB;
  logic       syncB, lockedB;
  logic [1:0] stateB;
  logic [15:0] errB;

  int checks = 0;
  int passed = 0;

  pueo_clk_phase_track #(
    .PERIOD(4), .SYNC_STAGES(3), .EDGE_MODE("RISE"), .OFFSET(0),
    .LOCK_COUNT(4), .UNLOCK_COUNT(2), .TIMEOUT(64), .ERR_W(16)
  ) dutA (
    .aclk(aclk), .aresetn(aresetnA), .sync_toggle_i(toggleA), .err_clr_i(errClrA),
    .phase_o(phaseA), .sync_o(syncA), .locked_o(lockedA), .state_o(stateA),
    .err_cnt_o(errA)
  );

  pueo_clk_phase_track #(
    .PERIOD(4), .SYNC_STAGES(3), .EDGE_MODE("BOTH"), .OFFSET(0),
    .LOCK_COUNT(4), .UNLOCK_COUNT(2), .TIMEOUT(64), .ERR_W(16)
  ) dutB (
    .aclk(aclk), .aresetn(aresetnB), .sync_toggle_i(toggleB), .err_clr_i(errClrB),
    .phase_o(phaseB), .sync_o(syncB), .locked_o(lockedB), .state_o(stateB),
    .err_cnt_o(errB)
  );

  // One table row per rising toggle on instance A. gap is the number of
  // cycles until the next rise; expected values hold right after the
  // detection edge (state/locked/err) and one edge later (phase/sync).
  typedef struct {
    int         gap;
    bit         clr;
    logic [1:0] expState;
    bit         expLocked;
    logic [15:0] expErr;
    logic [3:0] expPhase;
  } vec_t;

  vec_t vecs[16];

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A rise driven right after edge n is sampled at n+1, leaves the sync
  // chain at n+3, and is acted on at detection edge n+4; phase_o reflects
  // the (possibly reloaded) counter one edge later.
  task automatic applyStimulus(input vec_t v, input int idx);
    toggleA = 1'b1;
    errClrA = 1'b0;
    tick; tick; tick;
    errClrA = v.clr;
    tick;
    errClrA = 1'b0;
    checkOutput($sformatf("A row%0d state", idx), 32'(stateA), 32'(v.expState));
    checkOutput($sformatf("A row%0d locked", idx), 32'(lockedA), 32'(v.expLocked));
    checkOutput($sformatf("A row%0d err", idx), 32'(errA), 32'(v.expErr));
    toggleA = 1'b0;
    tick;
    checkOutput($sformatf("A row%0d phase", idx), 32'(phaseA), 32'(v.expPhase));
    checkOutput($sformatf("A row%0d sync", idx), 32'(syncA), 32'(v.expPhase[0]));
    repeat (v.gap - 5) tick;
  endtask

  task automatic flipB(input int idx, input logic [1:0] expState, input bit expLocked);
    toggleB = ~toggleB;
    repeat (4) tick;
    checkOutput($sformatf("B edge%0d state", idx), 32'(stateB), 32'(expState));
    checkOutput($sformatf("B edge%0d locked", idx), 32'(lockedB), 32'(expLocked));
  endtask

  initial begin
    logic [3:0] rot [4];
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000;

    // gap, clr, state, locked, err, phase
    vecs[0]  = '{8, 1'b0, 2'd1, 1'b0, 16'd0, 4'b0001}; // first edge realigns
    vecs[1]  = '{8, 1'b0, 2'd1, 1'b0, 16'd0, 4'b0001};
    vecs[2]  = '{8, 1'b0, 2'd1, 1'b0, 16'd0, 4'b0001};
    vecs[3]  = '{8, 1'b0, 2'd1, 1'b0, 16'd0, 4'b0001};
    vecs[4]  = '{8, 1'b0, 2'd2, 1'b1, 16'd0, 4'b0001}; // 5th edge locks
    vecs[5]  = '{9, 1'b0, 2'd2, 1'b1, 16'd0, 4'b0001};
    vecs[6]  = '{7, 1'b0, 2'd2, 1'b1, 16'd1, 4'b0010}; // late by one, tolerated
    vecs[7]  = '{9, 1'b0, 2'd2, 1'b1, 16'd1, 4'b0001}; // back on grid
    vecs[8]  = '{8, 1'b0, 2'd2, 1'b1, 16'd2, 4'b0010}; // shifted, miss 1
    vecs[9]  = '{8, 1'b0, 2'd1, 1'b0, 16'd3, 4'b0001}; // shifted, miss 2 realigns
    vecs[10] = '{8, 1'b0, 2'd1, 1'b0, 16'd3, 4'b0001};
    vecs[11] = '{8, 1'b0, 2'd1, 1'b0, 16'd3, 4'b0001};
    vecs[12] = '{8, 1'b0, 2'd1, 1'b0, 16'd3, 4'b0001};
    vecs[13] = '{9, 1'b0, 2'd2, 1'b1, 16'd3, 4'b0001}; // relocked
    vecs[14] = '{7, 1'b1, 2'd2, 1'b1, 16'd0, 4'b0010}; // clear beats increment
    vecs[15] = '{5, 1'b0, 2'd2, 1'b1, 16'd0, 4'b0001};

    aresetnA = 1'b0; toggleA = 1'b0; errClrA = 1'b0;
    aresetnB = 1'b0; toggleB = 1'b0; errClrB = 1'b0;
    tick; tick;
    checkOutput("A reset phase", 32'(phaseA), 32'd0);
    checkOutput("A reset sync", 32'(syncA), 32'd0);
    checkOutput("A reset locked", 32'(lockedA), 32'd0);
    checkOutput("A reset state", 32'(stateA), 32'd0);
    checkOutput("A reset err", 32'(errA), 32'd0);

    // Phase rotates straight out of reset even while UNLOCKED.
    aresetnA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checkOutput($sformatf("A free phase%0d", i), 32'(phaseA), 32'(rot[i % 4]));
      checkOutput($sformatf("A free sync%0d", i), 32'(syncA), 32'((i % 4) == 0));
    end

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Toggle now idle; the last detection edge was 1 edge ago.
    repeat (62) tick;
    checkOutput("A wd before state", 32'(stateA), 32'd2);
    checkOutput("A wd before locked", 32'(lockedA), 32'd1);
    tick;
    checkOutput("A wd state", 32'(stateA), 32'd0);
    checkOutput("A wd locked", 32'(lockedA), 32'd0);
    checkOutput("A wd phase", 32'(phaseA), 32'(4'b1000));
    checkOutput("A wd err", 32'(errA), 32'd0);
    tick;
    checkOutput("A wd phase next", 32'(phaseA), 32'(4'b0001));
    checkOutput("A wd sync next", 32'(syncA), 32'd1);

    // Instance B: any toggle change is an edge; spacing 4 matches PERIOD.
    checkOutput("B reset state", 32'(stateB), 32'd0);
    checkOutput("B reset phase", 32'(phaseB), 32'd0);
    aresetnB = 1'b1;
    flipB(1, 2'd1, 1'b0);
    flipB(2, 2'd1, 1'b0);
    flipB(3, 2'd1, 1'b0);
    flipB(4, 2'd1, 1'b0);
    flipB(5, 2'd2, 1'b1);
    flipB(6, 2'd2, 1'b1);

    // One-cycle reset mid-lock with the toggle settled low.
    aresetnB = 1'b0;
    tick;
    checkOutput("B midreset phase", 32'(phaseB), 32'd0);
    checkOutput("B midreset sync", 32'(syncB), 32'd0);
    checkOutput("B midreset locked", 32'(lockedB), 32'd0);
    checkOutput("B midreset state", 32'(stateB), 32'd0);
    checkOutput("B midreset err", 32'(errB), 32'd0);
    aresetnB = 1'b1;
    toggleB = ~toggleB;
    tick;
    checkOutput("B post reset state", 32'(stateB), 32'd0);
    repeat (3) tick;
    checkOutput("B reacq state", 32'(stateB), 32'd1);
    flipB(8, 2'd1, 1'b0);
    flipB(9, 2'd1, 1'b0);
    flipB(10, 2'd1, 1'b0);
    flipB(11, 2'd2, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pueo_clk_phase_track.md
Name: pueo_clk_phase_track

Overview:
Parametrised successor to the fixed memclk/aclk phase aligners. It runs in one clock domain and synchronises an asynchronous sync toggle from the syncclk domain. From that toggle it generates a one-hot phase of programmable period and a sync pulse at a programmable offset. Unlike the earlier blocks, it verifies every subsequent sync edge against the running phase, with a lock state machine, tolerance of isolated misaligned edges, a loss-of-sync watchdog and an error counter. One instance per fabric clock (aclk, memclk, ...).

Parameters:
PERIOD, 4, phase period in clock cycles (>=2)
SYNC_STAGES, 3, synchroniser depth (>=2), all stages ASYNC_REG
EDGE_MODE, "RISE", "RISE" = rising toggle edges only; "BOTH" = both edges
OFFSET, 0, phase index at which sync_o fires (0..PERIOD-1)
LOCK_COUNT, 4, consecutive aligned edges required to lock (>=1)
UNLOCK_COUNT, 2, consecutive misaligned edges in LOCKED that force a realign (>=1)
TIMEOUT, 64, cycles without an edge before unlock; 0 disables the watchdog
ERR_W, 16, error counter width

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
sync_toggle_i  in  1  asynchronous toggle from the syncclk domain
err_clr_i  in  1  clears err_cnt_o
phase_o  out  PERIOD  registered one-hot phase; bit i high when the running phase is i
sync_o  out  1  one-cycle pulse per period at phase OFFSET
locked_o  out  1  high in LOCKED
state_o  out  2  0=UNLOCKED, 1=ACQUIRE, 2=LOCKED
err_cnt_o  out  ERR_W  saturating count of misaligned edges seen in LOCKED

Behaviour:
- Reset: aresetn sampled low at a posedge clears the sync chain, edge flop, phase counter, all counters and all outputs to 0, and sets state to UNLOCKED. It takes effect in any state and aborts any count in progress.
- Sync chain s[0..SYNC_STAGES-1] is followed by s_d.
  - RISE mode: edge = s[last] & ~s_d.
  - BOTH mode: edge = s[last] ^ s_d.
- phase_cnt (clog2(PERIOD) bits) free-runs 0..PERIOD-1 and wraps to 0. A realign loads 0 at the next edge of aclk.
- An edge is aligned when phase_cnt == PERIOD-1 in the detection cycle, i.e. the counter would wrap to 0 on its own.
- phase_o and sync_o are registered from phase_cnt (1-cycle latency).
  - Toggle first sampled high at aclk edge k -> sync_o (OFFSET=0) high after edge k+SYNC_STAGES+1.
- State machine, evaluated on each edge-detect cycle:
  - UNLOCKED: any edge -> realign; good_cnt=0; go to ACQUIRE.
  - ACQUIRE, aligned edge: good_cnt++. When good_cnt reaches LOCK_COUNT -> LOCKED, with miss_cnt=0.
  - ACQUIRE, misaligned edge: realign; good_cnt=0; stay in ACQUIRE.
  - LOCKED, aligned edge: miss_cnt=0.
  - LOCKED, misaligned edge: no realign (phase held); miss_cnt++; err_cnt_o++. When miss_cnt reaches UNLOCK_COUNT -> realign, good_cnt=0, go to ACQUIRE.
- Watchdog:
  - idle_cnt resets on every edge and otherwise increments, saturating.
  - When idle_cnt reaches TIMEOUT in ACQUIRE or LOCKED -> UNLOCKED. Phase keeps free-running; err_cnt_o is not incremented.
  - If an edge arrives in the same cycle the timeout is reached, the edge wins.
- locked_o and state_o are registered and change on the cycle after the deciding edge.
- err_cnt_o saturates at 2^ERR_W-1. If err_clr_i is high in the same cycle as an increment, clear wins (result 0).
- Phase output is never gated: phase_o and sync_o rotate in every state, including UNLOCKED after reset.

Test Plan:
1. Reset, PERIOD=4, OFFSET=0, toggle rising every 8 cycles, first rising edge sampled at aclk edge k -> sync_o first high after edge k+4, then every 4 cycles; phase_o sequence 0001,0010,0100,1000.
2. Same stimulus, LOCK_COUNT=4 -> state_o 0->1 after edge #1; locked_o rises the cycle after the 5th rising edge is detected; err_cnt_o=0.
3. While locked, one rising edge delayed by 1 cycle, then on-grid again -> phase_o/sync_o timing unchanged, err_cnt_o=1, locked_o stays 1, miss_cnt cleared by the next edge.
4. While locked, two consecutive edges shifted by +1 cycle (UNLOCK_COUNT=2) -> second edge realigns (sync_o moves 1 cycle later), locked_o=0, state_o=1, err_cnt_o=2. Relock after 4 further aligned edges.
5. Toggle stopped while locked, TIMEOUT=64 -> state_o=0 and locked_o=0 64 cycles after the last detected edge; phase_o keeps rotating. Pulsing err_clr_i together with a misaligned edge -> err_cnt_o=0.
6. EDGE_MODE="BOTH", toggle every 4 cycles -> locks after 5 edges. Then aresetn low for 1 cycle mid-LOCKED -> all outputs 0 after that edge and re-acquisition restarts from UNLOCKED.
